qgemm_core: RTL and testbench
=============================

// Module: qgemm_core
// PURPOSE
//  Quantized GEMM engine: C = Aq x Bq, A is VLEN x K, B is K x VLEN, C is VLEN x VLEN.
//  Fixed-point inputs are quantized to unsigned QBW-bit codes with a per-matrix scale and zero point.
//  Zero-point-corrected products accumulate in ACC_W-bit signed integers.
//  Standalone compute block: the host loads operands, pulses start and waits on done.
// PARAMETERS
//  VLEN=8     rows of A / columns of B and C
//  K=64       inner dimension
//  FP_W=32    element width; inputs signed Q16.16, outputs signed integer
//  SCALE_W=16 scale width; unsigned Q8.8 multiplier (inverse quant step)
//  QBW=8      quantized code width, unsigned
//  ACC_W=32   signed accumulator width
// PORTS
//  clk      in  1              rising-edge clock
//  rst      in  1              synchronous active-high reset
//  start    in  1              1-cycle request, honoured only in IDLE
//  A_fp     in  VLEN*K*FP_W    A[r][k] = element e=r*K+k at bits [(VLEN*K-1-e)*FP_W +: FP_W] (element 0 in MSBs)
//  B_fp     in  K*VLEN*FP_W    B[k][c] = element e=k*VLEN+c, packed like A (element 0 in MSBs)
//  scale_A  in  SCALE_W        A quant multiplier, Q8.8
//  scale_B  in  SCALE_W        B quant multiplier, Q8.8
//  zp_A     in  QBW            A zero point, unsigned
//  zp_B     in  QBW            B zero point, unsigned
//  C_fp     out VLEN*VLEN*FP_W C[r][c] at bits [(r*VLEN+c)*FP_W +: FP_W] (LSB-first), sign-extended ACC_W
//  done     out 1              high from completion until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, done=0, C_fp=0, all accumulators=0.
//  FSM IDLE->RUN->FIN->IDLE.
//  - IDLE & start: capture A_fp, B_fp, scales and zps into internal regs; clear accs; k=0; done<=0; go to RUN.
//  - RUN: one k per cycle for K cycles. Quantize column k of A and row k of B (2*VLEN quantizers).
//    Update all VLEN*VLEN accs in parallel: acc[r][c] += (qa[r]-zp_A)*(qb[c]-zp_B).
//    Products are signed (QBW+1)x(QBW+1). After k=K-1, go to FIN.
//  - FIN: C_fp <= accs (sign-extended to FP_W); done<=1; go to IDLE.
//  Latency: start sampled at edge 0; done and C_fp valid after edge K+1.
//  Quantizer: p = x*scale (signed 48-bit Q24.24); q = ((p + 2^23) >>> 24) + zp, round half up.
//  Clamp q to [0, 2^QBW-1].
//  Accumulators wrap modulo 2^ACC_W (unless the macro below is defined).
//  start while in RUN/FIN: ignored. Inputs may change freely after capture.
//  C_fp holds its value until the next FIN. done stays high in IDLE and drops on the edge that accepts start.
//  rst mid-operation: abort immediately to the reset state.
// CONFIGURATION
//  QGEMM_ACC_SAT_EN defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//  Undefined: two's-complement wrap.
// STRUCTURE
//  Package qgemm_pkg: state enum (IDLE/RUN/FIN), Q-format shift constants (QSHIFT=24, RND=2^23).
//  Package qgemm_pkg also holds the quantize function.
//  Sub-module qgemm_quant: one fixed-point to QBW quantizer with clamp, instantiated 2*VLEN times.
//  Accumulator array and FSM live in the top level.
// TESTING
//  1 A=B=all 1.0 (0x00010000), scales 0x0100, zps 0 -> every C=64; done after edge K+1.
//  2 As test 1 but zp_A=zp_B=10 -> q=11, corrected 1 -> every C=64.
//  3 A=2.0 (0x00020000), B=-1.0 (0xFFFF0000), zps 128 -> qa=130, qb=127 -> every C=-128 (0xFFFFFF80).
//  4 Clamp and round: A=300.0 with B=1.0, zps 0 -> C=16320 (qa=255).
//    A=0.5 (0x00008000) -> qa=1 -> C=64.
//    A=-5.0 -> qa=0 -> C=0.
//  5 Packing: A[r][0]=r.0, B[0][c]=c.0, all other elements 0, zps 0, scales 0x0100 -> C[r][c]=r*c.
//    Check word placement in C_fp.
//  6 Control: start pulsed during RUN -> ignored, one done only.
//    rst at k=10 -> done=0, C_fp=0; a new start then completes normally.

Source files
------------

// File: rtl/qgemm_pkg.sv
// Shared types, sizes and the fixed-point quantizer for the qgemm engine.
package qgemm_pkg;

  localparam int VLEN    = 8;
  localparam int K       = 64;
  localparam int FP_W    = 32;
  localparam int SCALE_W = 16;
  localparam int QBW     = 8;
  localparam int ACC_W   = 32;

  localparam int KW      = $clog2(K);
  localparam int QSHIFT  = 24;
  localparam int RND     = 1 << (QSHIFT - 1);

  // Q16.16 x Q8.8 product plus a guard bit for the unsigned scale
  localparam int PROD_W  = FP_W + SCALE_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  // Scale to Q24.24, round half up to an integer, add zero point, clamp to the code range
  function automatic logic [QBW-1:0] quantize(input logic [FP_W-1:0]    x,
                                              input logic [SCALE_W-1:0] scale,
                                              input logic [QBW-1:0]     zp);
    logic signed [PROD_W-1:0] p;
    logic signed [PROD_W-1:0] q;
    logic signed [PROD_W-1:0] qmax;
    qmax = $signed({{(PROD_W-QBW){1'b0}}, {QBW{1'b1}}});
    p = $signed(x) * $signed({1'b0, scale});
    q = ((p + PROD_W'(RND)) >>> QSHIFT) + $signed({{(PROD_W-QBW){1'b0}}, zp});
    if (q < 0)
      quantize = '0;
    else if (q > qmax)
      quantize = '1;
    else
      quantize = q[QBW-1:0];
  endfunction

endpackage

// File: rtl/qgemm_quant.sv
// One fixed-point to QBW-bit quantizer lane.
module qgemm_quant
  import qgemm_pkg::*;
(
  input  logic [FP_W-1:0]    x,
  input  logic [SCALE_W-1:0] scale,
  input  logic [QBW-1:0]     zp,
  output logic [QBW-1:0]     q
);

  // purely combinational: the captured operand is quantized in the cycle it is used
  always_comb q = quantize(x, scale, zp);

endmodule

// File: rtl/qgemm_core.sv
// Quantized GEMM engine: C = Aq x Bq, one inner-dimension step per cycle.
// Optional build macro QGEMM_ACC_SAT_EN: accumulators saturate instead of wrapping.
module qgemm_core
  import qgemm_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [VLEN*K*FP_W-1:0]    A_fp,
  input  logic [K*VLEN*FP_W-1:0]    B_fp,
  input  logic [SCALE_W-1:0]        scale_A,
  input  logic [SCALE_W-1:0]        scale_B,
  input  logic [QBW-1:0]            zp_A,
  input  logic [QBW-1:0]            zp_B,
  output logic [VLEN*VLEN*FP_W-1:0] C_fp,
  output logic                      done
);

  localparam int AW1 = ACC_W + 1;

  state_t                    state;
  logic [KW-1:0]             k;
  logic [FP_W-1:0]           a_m [VLEN][K];
  logic [FP_W-1:0]           b_m [K][VLEN];
  logic [SCALE_W-1:0]        sa, sb;
  logic [QBW-1:0]            za, zb;
  logic [VLEN-1:0][QBW-1:0]  qa, qb;
  logic signed [ACC_W-1:0]   acc [VLEN][VLEN];

  wire accept = (state == IDLE) && start;

  // One multiply-accumulate step with zero-point correction
  function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] acc_in,
                                                       input logic [QBW-1:0] a, input logic [QBW-1:0] az,
                                                       input logic [QBW-1:0] b, input logic [QBW-1:0] bz);
    logic signed [QBW:0]     da, db;
    logic signed [2*QBW+1:0] prod;
    logic signed [AW1-1:0]   sum;
    da   = $signed({1'b0, a}) - $signed({1'b0, az});
    db   = $signed({1'b0, b}) - $signed({1'b0, bz});
    prod = da * db;
    sum  = AW1'(acc_in) + AW1'(prod);
`ifdef QGEMM_ACC_SAT_EN
    if (sum > $signed({2'b00, {(ACC_W-1){1'b1}}}))
      acc_step = $signed({1'b0, {(ACC_W-1){1'b1}}});
    else if (sum < $signed({2'b11, {(ACC_W-1){1'b0}}}))
      acc_step = $signed({1'b1, {(ACC_W-1){1'b0}}});
    else
      acc_step = $signed(sum[ACC_W-1:0]);
`else
    acc_step = $signed(sum[ACC_W-1:0]);
`endif
  endfunction

  // Operand capture on an accepted start; the host may change inputs afterwards
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < VLEN; r++)
        for (int kk = 0; kk < K; kk++)
          a_m[r][kk] <= A_fp[(VLEN*K-1-(r*K+kk))*FP_W +: FP_W];
      for (int kk = 0; kk < K; kk++)
        for (int c = 0; c < VLEN; c++)
          b_m[kk][c] <= B_fp[(K*VLEN-1-(kk*VLEN+c))*FP_W +: FP_W];
      sa <= scale_A;
      sb <= scale_B;
      za <= zp_A;
      zb <= zp_B;
    end
  end

  // 2*VLEN quantizers: column k of A and row k of B
  for (genvar r = 0; r < VLEN; r++) begin : g_qa
    qgemm_quant u_q (.x(a_m[r][k]), .scale(sa), .zp(za), .q(qa[r]));
  end
  for (genvar c = 0; c < VLEN; c++) begin : g_qb
    qgemm_quant u_q (.x(b_m[k][c]), .scale(sb), .zp(zb), .q(qb[c]));
  end

  // Accumulator array: cleared on start, updated every RUN cycle
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int r = 0; r < VLEN; r++)
        for (int c = 0; c < VLEN; c++)
          acc[r][c] <= '0;
    end else if (state == RUN) begin
      for (int r = 0; r < VLEN; r++)
        for (int c = 0; c < VLEN; c++)
          acc[r][c] <= acc_step(acc[r][c], qa[r], za, qb[c], zb);
    end
  end

  // Control FSM with registered done and result
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      done  <= 1'b0;
      C_fp  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          k     <= '0;
          done  <= 1'b0;
        end
        RUN: begin
          k <= k + 1'b1;
          if (k == KW'(K-1)) state <= FIN;
        end
        FIN: begin
          for (int r = 0; r < VLEN; r++)
            for (int c = 0; c < VLEN; c++)
              C_fp[(r*VLEN+c)*FP_W +: FP_W] <= FP_W'(acc[r][c]);
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qgemm_core.sv
// Directed, table-driven bench for qgemm_core.
module tb_qgemm_core;
  import qgemm_pkg::*;

  logic                      clk = 1'b0;
  logic                      rst, start;
  logic [VLEN*K*FP_W-1:0]    A_fp;
  logic [K*VLEN*FP_W-1:0]    B_fp;
  logic [SCALE_W-1:0]        scale_A, scale_B;
  logic [QBW-1:0]            zp_A, zp_B;
  logic [VLEN*VLEN*FP_W-1:0] C_fp;
  logic                      done;

  int n_cmp = 0;
  int n_err = 0;

  qgemm_core dut (.clk(clk), .rst(rst), .start(start), .A_fp(A_fp), .B_fp(B_fp),
                  .scale_A(scale_A), .scale_B(scale_B), .zp_A(zp_A), .zp_B(zp_B),
                  .C_fp(C_fp), .done(done));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a, b;
    logic [15:0] sa, sb;
    logic [7:0]  za, zb;
    logic [31:0] c;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] b);
    for (int e = 0; e < VLEN*K; e++) A_fp[(VLEN*K-1-e)*FP_W +: FP_W] = a;
    for (int e = 0; e < K*VLEN; e++) B_fp[(K*VLEN-1-e)*FP_W +: FP_W] = b;
  endtask

  task automatic check_uniform(input string nm, input logic [31:0] exp);
    int bad;
    logic [31:0] got;
    bad = -1;
    got = 32'h0;
    for (int i = 0; i < VLEN*VLEN; i++)
      if (bad < 0 && C_fp[i*FP_W +: FP_W] !== exp) begin
        bad = i;
        got = C_fp[i*FP_W +: FP_W];
      end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL %s: C word %0d got %0h want %0h", nm, bad, got, exp);
    end
  endtask

  // start pulse accepted at edge 0, then count edges until done (bounded)
  task automatic run_op(input string nm, output int lat);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({nm, " done_drop"}, {31'b0, done}, 32'd0);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  initial begin
    int lat, bad, lowcnt;
    logic [31:0] got;

    vecs[0] = '{"ones",       32'h00010000, 32'h00010000, 16'h0100, 16'h0100, 8'd0,   8'd0,   32'd64};
    vecs[1] = '{"zp10",       32'h00010000, 32'h00010000, 16'h0100, 16'h0100, 8'd10,  8'd10,  32'd64};
    vecs[2] = '{"neg_zp128",  32'h00020000, 32'hFFFF0000, 16'h0100, 16'h0100, 8'd128, 8'd128, 32'hFFFFFF80};
    vecs[3] = '{"clamp_hi",   32'h012C0000, 32'h00010000, 16'h0100, 16'h0100, 8'd0,   8'd0,   32'd16320};
    vecs[4] = '{"round_half", 32'h00008000, 32'h00010000, 16'h0100, 16'h0100, 8'd0,   8'd0,   32'd64};
    vecs[5] = '{"clamp_lo",   32'hFFFB0000, 32'h00010000, 16'h0100, 16'h0100, 8'd0,   8'd0,   32'd0};
    vecs[6] = '{"round_down", 32'h00007FFF, 32'h00010000, 16'h0100, 16'h0100, 8'd0,   8'd0,   32'd0};
    vecs[7] = '{"scale2",     32'h00010000, 32'h00010000, 16'h0200, 16'h0100, 8'd0,   8'd0,   32'd128};

    rst = 1'b1; start = 1'b0; A_fp = '0; B_fp = '0;
    scale_A = '0; scale_B = '0; zp_A = '0; zp_B = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", {31'b0, done}, 32'd0);
    check_uniform("reset C", 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill(vecs[v].a, vecs[v].b);
      scale_A = vecs[v].sa; scale_B = vecs[v].sb;
      zp_A = vecs[v].za;    zp_B = vecs[v].zb;
      run_op(vecs[v].name, lat);
      chk({vecs[v].name, " latency"}, lat, K+1);
      check_uniform(vecs[v].name, vecs[v].c);
    end

    // packing: A[r][0]=r, B[0][c]=c, everything else 0 -> C[r][c]=r*c
    A_fp = '0; B_fp = '0;
    scale_A = 16'h0100; scale_B = 16'h0100; zp_A = '0; zp_B = '0;
    for (int r = 0; r < VLEN; r++) A_fp[(VLEN*K-1-r*K)*FP_W +: FP_W] = r << 16;
    for (int c = 0; c < VLEN; c++) B_fp[(K*VLEN-1-c)*FP_W +: FP_W] = c << 16;
    run_op("packing", lat);
    chk("packing latency", lat, K+1);
    bad = -1; got = 32'h0;
    for (int r = 0; r < VLEN; r++)
      for (int c = 0; c < VLEN; c++)
        if (bad < 0 && C_fp[(r*VLEN+c)*FP_W +: FP_W] !== 32'(r*c)) begin
          bad = r*VLEN+c;
          got = C_fp[(r*VLEN+c)*FP_W +: FP_W];
        end
    n_cmp++;
    if (bad >= 0) begin
      n_err++;
      $display("FAIL packing: C word %0d got %0h want %0h", bad, got, (bad/VLEN)*(bad%VLEN));
    end

    // start during RUN (with operands changed) and during FIN must be ignored
    fill(32'h00010000, 32'h00010000);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
      start = (lat == 5 || lat == K);
      if (lat == 5) fill(32'h00020000, 32'h00020000);
    end
    start = 1'b0;
    chk("ignore_start latency", lat, K+1);
    check_uniform("ignore_start C", 32'd64);
    lowcnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (!done) lowcnt++;
    end
    chk("done_hold", lowcnt, 0);
    check_uniform("C_hold", 32'd64);

    // reset while k=10 is being processed, then a clean run
    fill(32'h00010000, 32'h00010000);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort done", {31'b0, done}, 32'd0);
    check_uniform("abort C", 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op("after_abort", lat);
    chk("after_abort latency", lat, K+1);
    check_uniform("after_abort C", 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
